// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared constants and state encoding for the DSP48A1 multiply-accumulate sequencer.
package dsp48a1_pkg;

    localparam int P_W  = 48;
    localparam int AB_W = 18;

    // Slice opmode: X mux in [1:0], Z mux in [3:2]
    localparam logic [7:0] OPM_IDLE = 8'h00;
    localparam logic [7:0] OPM_MAC  = 8'h09;
    localparam logic [7:0] OPM_HOLD = 8'h08;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_DRAIN,
        ST_RESULT
    } state_t;

endpackage

// File: rtl/dsp_mac_sequencer_if.sv
// Command, operand and result handshakes between upstream producers and the MAC sequencer.
interface dsp_mac_sequencer_if #(
    parameter int LEN_W = 10
) ();
    import dsp48a1_pkg::*;

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [LEN_W-1:0]       cmd_len;
    logic                   op_valid;
    logic                   op_ready;
    logic signed [AB_W-1:0] op_a;
    logic signed [AB_W-1:0] op_b;
    logic                   res_valid;
    logic                   res_ready;
    logic [P_W-1:0]         res_data;
    logic                   res_carry;

    modport master (
        output cmd_valid, cmd_len, op_valid, op_a, op_b, res_ready,
        input  cmd_ready, op_ready, res_valid, res_data, res_carry
    );

    modport slave (
        input  cmd_valid, cmd_len, op_valid, op_a, op_b, res_ready,
        output cmd_ready, op_ready, res_valid, res_data, res_carry
    );

endinterface

// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP48A1 slice as a signed dot-product MAC: streams operand pairs,
// generates opmode/reset each cycle and returns the drained 48-bit sum.
module dsp_mac_sequencer
    import dsp48a1_pkg::*;
#(
    parameter int LEN_W    = 10,
    parameter int PIPE_LAT = 2
) (
    input  logic                CLK,
    input  logic                RST,
    dsp_mac_sequencer_if.slave  bus,
    output logic [AB_W-1:0]     dsp_A,
    output logic [AB_W-1:0]     dsp_B,
    output logic [7:0]          dsp_opmode,
    output logic                dsp_rst,
    input  logic [P_W-1:0]      dsp_P,
    input  logic                dsp_CARRYOUT
);

    localparam int DRAIN_W = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [LEN_W-1:0]   r_remaining;
    logic [DRAIN_W-1:0] r_drain_cnt;
    logic               r_issue_d;
    logic               r_dsp_rst;
    logic [P_W-1:0]     r_res_data;
    logic               r_res_carry;
    logic               w_issue;
    logic               w_drain_done;

    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_drain_done = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_state_next = (bus.cmd_len == '0) ? ST_DRAIN : ST_FEED;
                end
            end
            ST_FEED: begin
                if (bus.op_valid) begin
                    w_issue = 1'b1;
                    if (r_remaining == LEN_W'(1)) begin
                        w_state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Last of PIPE_LAT+1 drain edges: P now includes the final pair
                if (r_drain_cnt == DRAIN_W'(PIPE_LAT)) begin
                    w_drain_done = 1'b1;
                    w_state_next = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (bus.res_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_drain_cnt <= '0;
            r_issue_d   <= 1'b0;
            r_dsp_rst   <= 1'b1;
            r_res_data  <= '0;
            r_res_carry <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_issue_d <= w_issue;
            // Slice held in reset for exactly the cycles spent in IDLE
            r_dsp_rst <= (w_state_next == ST_IDLE);
            if (r_state == ST_IDLE && bus.cmd_valid) begin
                r_remaining <= bus.cmd_len;
            end else if (w_issue) begin
                r_remaining <= r_remaining - LEN_W'(1);
            end
            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + DRAIN_W'(1) : '0;
            if (w_drain_done) begin
                r_res_data  <= dsp_P;
                r_res_carry <= dsp_CARRYOUT;
            end
        end
    end

    always_comb begin
        dsp_opmode = OPM_HOLD;
        if (r_state == ST_IDLE) begin
            dsp_opmode = OPM_IDLE;
        end else if (r_issue_d) begin
            dsp_opmode = OPM_MAC;
        end
    end

    assign bus.cmd_ready = (r_state == ST_IDLE);
    assign bus.op_ready  = (r_state == ST_FEED);
    assign bus.res_valid = (r_state == ST_RESULT);
    assign bus.res_data  = r_res_data;
    assign bus.res_carry = r_res_carry;
    assign dsp_A         = bus.op_a;
    assign dsp_B         = bus.op_b;
    assign dsp_rst       = r_dsp_rst;

endmodule

// File: doc/dsp_mac_sequencer.md
# dsp_mac_sequencer

Sequencer that drives a single DSP48A1 slice as a signed multiply-accumulate engine for dot products. It accepts a command carrying the vector length, streams operand pairs into the slice over a valid/ready handshake, and generates the slice's opmode and reset on every cycle. It returns the 48-bit accumulated sum once the slice pipeline has drained. It sits between upstream producers and one DSP48A1 instance, which the sequencer owns exclusively.

## Interface
- `LEN_W`, default 10: width of `cmd_len`. The maximum vector length is 2^LEN_W − 1.
- `PIPE_LAT`, default 2: number of clock edges from the edge that captures a pair in the slice's A1/B1 registers to the P update that includes that pair.

- `CLK`, in, 1: clock, rising edge.
- `RST`, in, 1: asynchronous, active-high reset.
- `cmd_valid`, in, 1: command request.
- `cmd_ready`, out, 1: command accepted. High only in IDLE.
- `cmd_len`, in, LEN_W: number of operand pairs. 0 is legal.
- `op_valid`, in, 1: operand pair valid.
- `op_ready`, out, 1: pair accepted. High only in FEED.
- `op_a`, in, 18: signed multiplicand.
- `op_b`, in, 18: signed multiplier.
- `res_valid`, out, 1: result valid.
- `res_ready`, in, 1: result consumed.
- `res_data`, out, 48: accumulated sum.
- `res_carry`, out, 1: captured slice CARRYOUT.
- `dsp_A`, out, 18: connects to slice A. Combinational pass-through of `op_a`.
- `dsp_B`, out, 18: connects to slice B. Combinational pass-through of `op_b`.
- `dsp_opmode`, out, 8: connects to slice opmode.
- `dsp_rst`, out, 1: connects to RSTA/RSTB/RSTM/RSTP/RSTOPMODE/RSTCARRYIN.
- `dsp_P`, in, 48: slice P.
- `dsp_CARRYOUT`, in, 1: slice CARRYOUT.

Slice configuration for integration:
- A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODEREG=1.
- B input set to DIRECT.
- All CE pins tied to 1.
- C, D, PCIN, BCIN and CARRYIN tied to 0.

## Operation
FSM states are IDLE, FEED, DRAIN and RESULT.

- **IDLE**
  - `dsp_rst` is 1 (registered), so the slice's P, M and opmode registers read 0.
  - On `cmd_valid && cmd_ready`: latch `cmd_len` into `remaining`.
  - Go to FEED, or to DRAIN if `cmd_len == 0`.
- **FEED**
  - `op_ready` = 1.
  - Each `op_valid && op_ready` edge is an issue. It decrements `remaining`.
  - The issue that takes `remaining` to 0 moves the FSM to DRAIN.
- **DRAIN**
  - Counts PIPE_LAT+1 cycles from entry.
  - On the last edge: capture `res_data <= dsp_P` and `res_carry <= dsp_CARRYOUT`, then go to RESULT.
- **RESULT**
  - `res_valid` = 1. `res_data` and `res_carry` are held stable.
  - On `res_ready`: go to IDLE.

Opmode generation:
- `issue_d` is the issue strobe delayed by one register stage.
- `dsp_opmode` = 8'h09 when `issue_d` is 1: X = M, Z = P, add.
- `dsp_opmode` = 8'h08 otherwise: X = 0, Z = P. P holds through bubbles and after the last pair.
- `dsp_opmode` = 8'h00 in IDLE.

Arithmetic:
- Signed 18×18 → 36-bit product, sign-extended by the slice.
- The sum wraps modulo 2^48; there is no saturation.
- At LEN_W = 10, the sum cannot overflow.

Reset values: `cmd_ready`=1, `op_ready`=0, `res_valid`=0, `res_data`=0, `res_carry`=0, `dsp_opmode`=0, `dsp_rst`=1, FSM in IDLE.

## Timing
- Issue at edge e:
  - The pair is captured in A1/B1 at e.
  - `dsp_opmode` = 09 during cycle (e, e+1) and is captured in the opmode register at e+1, together with M.
  - P is updated at e+PIPE_LAT.
- For a last issue at edge e_last:
  - `res_valid` rises after edge e_last+PIPE_LAT+1.
  - `res_data` equals `dsp_P` as updated at e_last+PIPE_LAT.
- `cmd_len` = 0: `res_valid` rises PIPE_LAT+1 edges after command accept, with `res_data` = 0.
- Bubbles (`op_valid` low in FEED): no issue occurs, opmode is 08 one cycle later, and P is unchanged.
- `dsp_rst` falls on the edge that accepts the command and rises on the edge that returns the FSM to IDLE.
- The earliest next command is accepted on the cycle after the result handshake.
- `RST` mid-operation: immediate return to IDLE with reset values. The in-flight vector is discarded and no result is produced. The next command behaves normally.
- `res_ready` held low: `res_valid`, `res_data` and `res_carry` are held indefinitely. `cmd_ready` and `op_ready` stay 0.

## Structure
- Package `dsp48a1_pkg` holds:
  - `OPM_IDLE` = 8'h00
  - `OPM_MAC` = 8'h09
  - `OPM_HOLD` = 8'h08
  - the state enum
  - the P width (48) and the A/B width (18)
- Single module with no sub-module. The FSM, `remaining` counter, drain counter, `issue_d` register and result registers are all local.

## Test plan
1. len=3; pairs (2,3), (4,5), (−1,7) back-to-back → `res_data` = 19, `res_valid` at e_last+3.
2. Same vector with 2-cycle `op_valid` gaps between pairs → `res_data` = 19, and `dsp_opmode` = 08 during the gap cycles.
3. len=0 → `res_data` = 0 after 3 edges. `op_ready` never asserts.
4. len=4, each pair (−131072, −131072) → `res_data` = 48'h0010_0000_0000.
5. `res_ready` low for 5 cycles, then two back-to-back commands: len=2 with (1,1),(1,1), then len=1 with (−3,5) → results 2, then 48'hFFFF_FFFF_FFF1. Outputs stay stable while stalled.
6. Assert `RST` after 2 of 4 pairs → all outputs return to reset values. A following len=1 with (6,7) → 42.
